// File: rtl/led_trail_pwm_if.sv
// Pattern-in / LED-out bundle between the pattern generator, the trail PWM stage and the pins.
interface led_trail_pwm_if;
   logic       en;
   logic [7:0] pat_in;
   logic [7:0] led_out;
   logic       trail_active;

   modport master (output en, output pat_in, input led_out, input trail_active);
   modport slave  (input en, input pat_in, output led_out, output trail_active);
endinterface

// File: rtl/led_trail_pwm.sv
// Drives eight LEDs with PWM; each LED jumps to full brightness when its pattern bit is
// high and then fades by DECAY_STEP every DECAY_DIV cycles, leaving a trail behind the sweep.
module led_trail_pwm #(
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned DECAY_DIV  = 65536,
   parameter int unsigned DECAY_STEP = 16
) (
   input  logic            clk,
   input  logic            rstn,
   led_trail_pwm_if.slave  bus
);

   localparam int unsigned W        = PWM_BITS;
   localparam int unsigned N_LED    = 8;
   localparam int unsigned PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [W-1:0]     MAX_B    = {W{1'b1}};
   localparam logic [W-1:0]     CNT_LAST = MAX_B - W'(1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_DIV - 1);
   localparam logic [W:0]       STEP_X   = (W+1)'(DECAY_STEP);

   logic [PRE_W-1:0] pre_q;
   logic [W-1:0]     cnt_q;
   logic [W-1:0]     bri_q [N_LED];
   logic [W-1:0]     bri_d [N_LED];
   logic [W:0]       diff_c [N_LED];
   logic [N_LED-1:0] led_d;
   logic [N_LED-1:0] lit_c;
   logic [N_LED-1:0] led_q;
   logic             active_q;
   logic             tick_c;

   assign tick_c = bus.en && (pre_q == PRE_LAST);

   // Decay prescaler and PWM ramp; both restart from zero whenever the block is disabled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else if (!bus.en) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
         cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + W'(1);
      end
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_led
      // Refresh beats decay; the extra top bit of the difference flags an underflow.
      always_comb begin
         diff_c[i] = {1'b0, bri_q[i]} - STEP_X;
         bri_d[i]  = bri_q[i];
         if (!bus.en) begin
            bri_d[i] = '0;
         end else if (bus.pat_in[i]) begin
            bri_d[i] = MAX_B;
         end else if (tick_c) begin
            bri_d[i] = diff_c[i][W] ? '0 : diff_c[i][W-1:0];
         end
         lit_c[i] = (bri_q[i] != '0);
         led_d[i] = bus.en && (cnt_q < bri_q[i]);
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            bri_q[i] <= '0;
         end else begin
            bri_q[i] <= bri_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         led_q    <= '0;
         active_q <= 1'b0;
      end else begin
         led_q    <= led_d;
         active_q <= bus.en && (|lit_c);
      end
   end

   assign bus.led_out      = led_q;
   assign bus.trail_active = active_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Self-checking bench for led_trail_pwm: vector table, directed corner sequences and
// randomized patterns against a brightness/duty reference model.
module tb_led_trail_pwm;

   localparam int MAXB  = 255;
   localparam int STEP  = 64;
   localparam int DIV   = 4;
   localparam int DIV2  = 4096;

   logic clk   = 1'b0;
   logic rstn  = 1'b1;
   logic rstn2 = 1'b1;

   always #5 clk = ~clk;

   led_trail_pwm_if bus  ();
   led_trail_pwm_if bus2 ();

   led_trail_pwm #(.PWM_BITS(8), .DECAY_DIV(DIV), .DECAY_STEP(STEP)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   led_trail_pwm #(.PWM_BITS(8), .DECAY_DIV(DIV2), .DECAY_STEP(STEP)) dut_duty (
      .clk  (clk),
      .rstn (rstn2),
      .bus  (bus2)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: brightness as integers, time as enabled edges since restart.
   int         mb [8];
   int         mn;
   logic [7:0] exp_led;
   logic       exp_ta;

   typedef struct {
      logic       en;
      logic [7:0] pat;
      logic [7:0] led;
      logic       ta;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %02h expected %02h", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mb[i] = 0;
      mn      = 0;
      exp_led = 8'h00;
      exp_ta  = 1'b0;
   endtask

   task automatic model_edge();
      bit tick;
      if (!rstn || !bus.en) begin
         model_clear();
      end else begin
         exp_ta = 1'b0;
         for (int i = 0; i < 8; i++) begin
            exp_led[i] = ((mn % MAXB) < mb[i]);
            if (mb[i] != 0) exp_ta = 1'b1;
         end
         tick = ((mn % DIV) == DIV - 1);
         for (int i = 0; i < 8; i++) begin
            if (bus.pat_in[i])  mb[i] = MAXB;
            else if (tick)      mb[i] = (mb[i] > STEP) ? mb[i] - STEP : 0;
         end
         mn++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_led", bus.led_out, exp_led);
      chk("model_ta", {7'b0, bus.trail_active}, {7'b0, exp_ta});
   endtask

   task automatic restart();
      bus.en     = 1'b0;
      bus.pat_in = 8'h00;
      step();
      bus.en = 1'b1;
   endtask

   task automatic async_reset_pulse(input string name);
      #3;
      rstn = 1'b0;
      #1;
      chk({name, "_led"}, bus.led_out, 8'h00);
      chk({name, "_ta"}, {7'b0, bus.trail_active}, 8'h00);
      model_clear();
      #2;
      rstn = 1'b1;
   endtask

   initial begin
      int hi, hi_full, other;

      tbl[0] = '{1'b1, 8'h01, 8'h00, 1'b0};
      tbl[1] = '{1'b1, 8'h00, 8'h01, 1'b1};
      tbl[2] = '{1'b1, 8'h80, 8'h01, 1'b1};
      tbl[3] = '{1'b1, 8'h00, 8'h81, 1'b1};
      tbl[4] = '{1'b0, 8'hFF, 8'h00, 1'b0};
      tbl[5] = '{1'b1, 8'hFF, 8'h00, 1'b0};
      tbl[6] = '{1'b1, 8'h00, 8'hFF, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b0};
      tbl[8] = '{1'b1, 8'h00, 8'h00, 1'b0};
      tbl[9] = '{1'b1, 8'h00, 8'h00, 1'b0};

      model_clear();
      bus.en      = 1'b1;
      bus.pat_in  = 8'hFF;
      bus2.en     = 1'b0;
      bus2.pat_in = 8'h00;

      // Reset asserted with no clock edge, then released before the first edge.
      #2;
      rstn  = 1'b0;
      rstn2 = 1'b0;
      #1;
      chk("rst_led", bus.led_out, 8'h00);
      chk("rst_ta", {7'b0, bus.trail_active}, 8'h00);
      #1;
      rstn  = 1'b1;
      rstn2 = 1'b1;
      step();
      chk("rst_first_edge", bus.led_out, 8'h00);
      step();
      chk("rst_second_edge", bus.led_out, 8'hFF);
      chk("rst_second_ta", {7'b0, bus.trail_active}, 8'h01);

      // Vector table from a clean restart.
      restart();
      for (int r = 0; r < 10; r++) begin
         bus.en     = tbl[r].en;
         bus.pat_in = tbl[r].pat;
         step();
         chk($sformatf("vec%0d_led", r), bus.led_out, tbl[r].led);
         chk($sformatf("vec%0d_ta", r), {7'b0, bus.trail_active}, {7'b0, tbl[r].ta});
      end

      // Single-cycle pulse decays 255,191,127,63,0 and then stays at zero.
      restart();
      bus.pat_in = 8'h01;
      step();
      bus.pat_in = 8'h00;
      for (int n = 1; n <= 15; n++) begin
         step();
         chk("decay_ta_on", {7'b0, bus.trail_active}, 8'h01);
      end
      step();
      chk("decay_ta_off", {7'b0, bus.trail_active}, 8'h00);
      for (int n = 0; n < 12; n++) begin
         step();
         chk("decay_nowrap_led", bus.led_out, 8'h00);
         chk("decay_nowrap_ta", {7'b0, bus.trail_active}, 8'h00);
      end

      // Held refresh across ticks, then released exactly on a tick cycle.
      restart();
      bus.pat_in = 8'h80;
      step();
      for (int n = 0; n < 12; n++) begin
         step();
         chk("hold_led7", {7'b0, bus.led_out[7]}, 8'h01);
      end
      while ((mn % DIV) != DIV - 1) step();
      step();
      bus.pat_in = 8'h00;
      for (int n = 0; n < 24; n++) step();

      // Disable mid-trail, keep pattern high while disabled.
      restart();
      bus.pat_in = 8'h0F;
      step();
      bus.pat_in = 8'h00;
      for (int n = 0; n < 5; n++) step();
      bus.en     = 1'b0;
      bus.pat_in = 8'hFF;
      step();
      chk("en_off_led", bus.led_out, 8'h00);
      chk("en_off_ta", {7'b0, bus.trail_active}, 8'h00);
      for (int n = 0; n < 5; n++) begin
         step();
         chk("en_off_hold", bus.led_out, 8'h00);
      end
      bus.en     = 1'b1;
      bus.pat_in = 8'h10;
      step();
      bus.pat_in = 8'h00;
      for (int n = 0; n < 20; n++) step();
      async_reset_pulse("midpwm_rst");
      for (int n = 0; n < 6; n++) step();

      // Knight-rider style sweep, two lit bits shifting every 8 cycles.
      restart();
      for (int k = 0; k < 7; k++) begin
         bus.pat_in = 8'hC0 >> k;
         for (int j = 0; j < 8; j++) begin
            step();
            if (!(k == 0 && j == 0))
               chk("sweep_ta", {7'b0, bus.trail_active}, 8'h01);
         end
      end
      bus.pat_in = 8'h00;
      for (int n = 0; n < 24; n++) step();

      // Randomized patterns with occasional disables.
      restart();
      for (int n = 0; n < 2000; n++) begin
         bus.en     = (($urandom % 50) != 0);
         bus.pat_in = 8'($urandom & $urandom & $urandom);
         step();
      end

      // Duty measurement on the long-prescaler instance.
      @(posedge clk);
      #1;
      bus2.pat_in = 8'h08;
      bus2.en     = 1'b1;
      hi = 0; hi_full = 0; other = 0;
      for (int n = 0; n < 4351; n++) begin
         @(posedge clk);
         #1;
         if (n == 0) bus2.pat_in = 8'h00;
         if ((bus2.led_out & 8'hF7) != 8'h00) other++;
         if (n >= 256 && n <= 510 && bus2.led_out[3]) hi_full++;
         if (n >= 4096 && bus2.led_out[3]) hi++;
      end
      chk_int("duty_full", hi_full, 255);
      chk_int("duty_after_tick", hi, 191);
      chk_int("duty_other_leds", other, 0);
      chk("duty_ta", {7'b0, bus2.trail_active}, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
